// File: rtl/airhockey_pkg.sv
// Shared air-hockey definitions: display geometry defaults, paddle FSM states
// and the index-to-mask decode that the ball/collision logic also uses.
package airhockey_pkg;

    localparam int ROWS_DEF    = 8;
    localparam int PAD_LEN_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } pad_state_t;

    function automatic int home_idx(input int rows, input int pad_len);
        return (rows - pad_len + 1) / 2;
    endfunction

    function automatic int max_idx(input int rows, input int pad_len);
        return rows - pad_len;
    endfunction

    // Result is wide enough for any column height; callers cast to their row count.
    function automatic logic [63:0] mask_from_idx(input int idx, input int pad_len);
        logic [63:0] ones;
        ones = (64'd1 << pad_len) - 64'd1;
        return ones << idx;
    endfunction

endpackage

// File: rtl/paddle_ctrl_multi_if.sv
// Paddle command/position bundle: per-paddle controls in, lit-row masks, indices and limit flags out.
interface paddle_ctrl_multi_if #(
    parameter int NUM_PADS = 2,
    parameter int ROWS     = 8,
    parameter int IDXW     = 3
);
    logic                     tick;
    logic [NUM_PADS-1:0]      en;
    logic [NUM_PADS-1:0]      up;
    logic [NUM_PADS-1:0]      center;
    logic [NUM_PADS*ROWS-1:0] pos_mask;
    logic [NUM_PADS*IDXW-1:0] pos_idx;
    logic [NUM_PADS-1:0]      at_top;
    logic [NUM_PADS-1:0]      at_bot;

    modport master (
        output tick, en, up, center,
        input  pos_mask, pos_idx, at_top, at_bot
    );

    modport slave (
        input  tick, en, up, center,
        output pos_mask, pos_idx, at_top, at_bot
    );
endinterface

// File: rtl/paddle_chan.sv
// One paddle: hold-to-auto-repeat move FSM, tick counter and saturating row index.
//   state  | meaning
//   IDLE   | button released; next qualifying tick steps immediately
//   HOLD   | stepped once, counting ticks until auto-repeat starts
//   REPEAT | auto-repeating, one step every REPEAT_RATE ticks
module paddle_chan
    import airhockey_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int PAD_LEN     = 3,
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 2,
    parameter int IDXW        = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            en,
    input  logic            up,
    input  logic            center,
    output logic [ROWS-1:0] pos_mask,
    output logic [IDXW-1:0] pos_idx,
    output logic            at_top,
    output logic            at_bot
);

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNTW    = $clog2(CNT_MAX) + 1;

    localparam logic [IDXW-1:0] HOME    = IDXW'(home_idx(ROWS, PAD_LEN));
    localparam logic [IDXW-1:0] MAXI    = IDXW'(max_idx(ROWS, PAD_LEN));
    localparam logic [CNTW-1:0] DLY_TC  = CNTW'(REPEAT_DLY - 1);
    localparam logic [CNTW-1:0] RATE_TC = CNTW'(REPEAT_RATE - 1);

    pad_state_t      state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [IDXW-1:0] idx, idx_n;
    logic            dir, dir_n;
    logic            do_step;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= HOME;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            dir   <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        dir_n   = dir;
        do_step = 1'b0;

        if (center) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = HOME;
        end else if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (tick) begin
            // A direction change while held is handled exactly like a fresh press.
            if (state == IDLE || up != dir) begin
                do_step = 1'b1;
                dir_n   = up;
                cnt_n   = '0;
                state_n = HOLD;
            end else if (state == HOLD) begin
                if (cnt == DLY_TC) begin
                    do_step = 1'b1;
                    cnt_n   = '0;
                    state_n = REPEAT;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end else begin
                if (cnt == RATE_TC) begin
                    do_step = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end

            // At a wall the FSM keeps its cadence; only the index saturates.
            if (do_step) begin
                if (up && idx < MAXI) begin
                    idx_n = idx + IDXW'(1);
                end else if (!up && idx != '0) begin
                    idx_n = idx - IDXW'(1);
                end
            end
        end
    end

    assign pos_idx  = idx;
    assign pos_mask = ROWS'(mask_from_idx(int'(idx), PAD_LEN));
    assign at_top   = (idx == MAXI);
    assign at_bot   = (idx == '0);

endmodule

// File: rtl/paddle_ctrl_multi.sv
// NUM_PADS independent paddle channels packed onto the shared position bus.
module paddle_ctrl_multi
    import airhockey_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int PAD_LEN     = PAD_LEN_DEF,
    parameter int NUM_PADS    = 2,
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 2,
    parameter int IDXW        = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               reset,
    paddle_ctrl_multi_if.slave bus
);

    logic [NUM_PADS*ROWS-1:0] mask_w;
    logic [NUM_PADS*IDXW-1:0] idx_w;
    logic [NUM_PADS-1:0]      top_w;
    logic [NUM_PADS-1:0]      bot_w;

    for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
        paddle_chan #(
            .ROWS        (ROWS),
            .PAD_LEN     (PAD_LEN),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE),
            .IDXW        (IDXW)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .tick     (bus.tick),
            .en       (bus.en[k]),
            .up       (bus.up[k]),
            .center   (bus.center[k]),
            .pos_mask (mask_w[k*ROWS +: ROWS]),
            .pos_idx  (idx_w[k*IDXW +: IDXW]),
            .at_top   (top_w[k]),
            .at_bot   (bot_w[k])
        );
    end

    assign bus.pos_mask = mask_w;
    assign bus.pos_idx  = idx_w;
    assign bus.at_top   = top_w;
    assign bus.at_bot   = bot_w;

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Bench for paddle_ctrl_multi: vector table, corner sequences and random traffic against a held-tick model.
module tb_paddle_ctrl_multi;

    localparam int ROWS    = 8;
    localparam int PAD_LEN = 3;
    localparam int NP      = 2;
    localparam int DLY     = 4;
    localparam int RATE    = 2;
    localparam int IDXW    = 3;
    localparam int HOME    = (ROWS - PAD_LEN + 1) / 2;
    localparam int MAXI    = ROWS - PAD_LEN;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    paddle_ctrl_multi_if #(.NUM_PADS(NP), .ROWS(ROWS), .IDXW(IDXW)) bus ();

    paddle_ctrl_multi #(
        .ROWS(ROWS), .PAD_LEN(PAD_LEN), .NUM_PADS(NP),
        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .IDXW(IDXW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int errs    = 0;

    // Model: a held button is described by how many qualifying ticks have passed since the press.
    int m_idx  [NP];
    int m_held [NP];
    bit m_act  [NP];
    bit m_dir  [NP];

    typedef struct {
        logic       t;
        logic [1:0] e;
        logic [1:0] u;
        logic [1:0] c;
        int         e0;
        int         e1;
        int         m0;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int get_idx(input int k);
        return int'(bus.pos_idx[k*IDXW +: IDXW]);
    endfunction

    function automatic int get_mask(input int k);
        return int'(bus.pos_mask[k*ROWS +: ROWS]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            m_idx[k]  = HOME;
            m_held[k] = 0;
            m_act[k]  = 1'b0;
            m_dir[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit stp;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NP; k++) begin
            stp = 1'b0;
            if (bus.center[k]) begin
                m_idx[k] = HOME;
                m_act[k] = 1'b0;
            end else if (!bus.en[k]) begin
                m_act[k] = 1'b0;
            end else if (bus.tick) begin
                if (!m_act[k] || bus.up[k] != m_dir[k]) begin
                    m_act[k]  = 1'b1;
                    m_dir[k]  = bus.up[k];
                    m_held[k] = 0;
                    stp       = 1'b1;
                end else begin
                    m_held[k]++;
                    if (m_held[k] == DLY ||
                        (m_held[k] > DLY && (m_held[k] - DLY) % RATE == 0))
                        stp = 1'b1;
                end
                if (stp) begin
                    if (bus.up[k]) m_idx[k] = (m_idx[k] < MAXI) ? m_idx[k] + 1 : m_idx[k];
                    else           m_idx[k] = (m_idx[k] > 0)    ? m_idx[k] - 1 : 0;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("model_idx%0d@%0t", k, $time), get_idx(k), m_idx[k]);
            chk($sformatf("model_mask%0d@%0t", k, $time), get_mask(k),
                ((1 << PAD_LEN) - 1) << m_idx[k]);
            chk($sformatf("model_top%0d@%0t", k, $time), int'(bus.at_top[k]),
                (m_idx[k] == MAXI) ? 1 : 0);
            chk($sformatf("model_bot%0d@%0t", k, $time), int'(bus.at_bot[k]),
                (m_idx[k] == 0) ? 1 : 0);
        end
    endtask

    task automatic cyc(input logic t, input logic [1:0] e, input logic [1:0] u,
                       input logic [1:0] c);
        bus.tick   = t;
        bus.en     = e;
        bus.up     = u;
        bus.center = c;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic add(input logic t, input logic [1:0] e, input logic [1:0] u,
                       input logic [1:0] c, input int e0, input int e1, input int m0);
        vec_t v;
        v.t = t; v.e = e; v.u = u; v.c = c; v.e0 = e0; v.e1 = e1; v.m0 = m0;
        tbl.push_back(v);
    endtask

    initial begin
        logic [1:0] r_en, r_up, r_c;
        int maxv;

        bus.tick = 1'b0; bus.en = '0; bus.up = '0; bus.center = '0;
        model_reset();
        reset = 1'b0;
        cyc(0, 2'b00, 2'b00, 2'b00);
        cyc(0, 2'b00, 2'b00, 2'b00);
        reset = 1'b1;
        cyc(0, 2'b00, 2'b00, 2'b00);
        chk("rst_mask", int'(bus.pos_mask), 16'h3838);
        chk("rst_idx", int'(bus.pos_idx), 27);
        chk("rst_top", int'(bus.at_top), 0);
        chk("rst_bot", int'(bus.at_bot), 0);

        // Paddle 0: press up, repeat into the top wall, reverse, release, recenter.
        add(1, 2'b01, 2'b01, 2'b00, 4, 3, 8'h70);
        add(0, 2'b01, 2'b01, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b01, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b01, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b01, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b01, 2'b00, 5, 3, 8'hE0);
        add(1, 2'b01, 2'b01, 2'b00, 5, 3, 8'hE0);
        add(1, 2'b01, 2'b01, 2'b00, 5, 3, 8'hE0);
        add(1, 2'b01, 2'b00, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b00, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b00, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b00, 2'b00, 4, 3, 8'h70);
        add(1, 2'b01, 2'b00, 2'b00, 3, 3, 8'h38);
        add(1, 2'b01, 2'b00, 2'b00, 3, 3, 8'h38);
        add(1, 2'b01, 2'b00, 2'b00, 2, 3, 8'h1C);
        add(0, 2'b01, 2'b00, 2'b00, 2, 3, 8'h1C);
        add(1, 2'b01, 2'b00, 2'b00, 2, 3, 8'h1C);
        add(1, 2'b01, 2'b00, 2'b00, 1, 3, 8'h0E);
        add(1, 2'b00, 2'b00, 2'b00, 1, 3, 8'h0E);
        add(1, 2'b01, 2'b00, 2'b00, 0, 3, 8'h07);
        add(1, 2'b01, 2'b00, 2'b00, 0, 3, 8'h07);
        add(1, 2'b01, 2'b01, 2'b01, 3, 3, 8'h38);
        add(1, 2'b01, 2'b01, 2'b00, 4, 3, 8'h70);

        foreach (tbl[i]) begin
            cyc(tbl[i].t, tbl[i].e, tbl[i].u, tbl[i].c);
            chk($sformatf("tbl%0d_idx0", i), get_idx(0), tbl[i].e0);
            chk($sformatf("tbl%0d_idx1", i), get_idx(1), tbl[i].e1);
            chk($sformatf("tbl%0d_mask0", i), get_mask(0), tbl[i].m0);
        end

        // Saturation against the top wall.
        maxv = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 2'b01, 2'b01, 2'b00);
            if (get_idx(0) > maxv) maxv = get_idx(0);
        end
        chk("sat_up_max", maxv, 5);
        chk("sat_up_idx", get_idx(0), 5);
        chk("sat_up_mask", get_mask(0), 8'hE0);
        chk("sat_up_top", int'(bus.at_top[0]), 1);

        // Reset while held at idx 5 returns home and aborts the repeat.
        reset = 1'b0;
        cyc(1, 2'b01, 2'b01, 2'b00);
        chk("rst_hold_idx", get_idx(0), 3);
        reset = 1'b1;
        cyc(1, 2'b01, 2'b01, 2'b00);
        chk("rst_hold_restep", get_idx(0), 4);

        for (int i = 0; i < 20; i++) cyc(1, 2'b01, 2'b00, 2'b00);
        chk("sat_dn_idx", get_idx(0), 0);
        chk("sat_dn_mask", get_mask(0), 8'h07);
        chk("sat_dn_bot", int'(bus.at_bot[0]), 1);

        // Reversal while repeating at idx 4.
        cyc(0, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 9; i++) cyc(1, 2'b01, 2'b01, 2'b00);
        chk("rev_pre_idx", get_idx(0), 4);
        cyc(1, 2'b01, 2'b00, 2'b00);
        chk("rev_step_idx", get_idx(0), 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 2'b01, 2'b00, 2'b00);
            chk($sformatf("rev_wait%0d", i), get_idx(0), 3);
        end
        cyc(1, 2'b01, 2'b00, 2'b00);
        chk("rev_next_idx", get_idx(0), 2);

        // Center beats a held move on paddle 1.
        for (int i = 0; i < 10; i++) cyc(1, 2'b10, 2'b00, 2'b00);
        chk("ctr_pre_idx1", get_idx(1), 0);
        cyc(1, 2'b10, 2'b10, 2'b10);
        chk("ctr_idx1", get_idx(1), 3);
        cyc(1, 2'b10, 2'b10, 2'b00);
        chk("ctr_after_idx1", get_idx(1), 4);

        // Opposite moves on the same tick; paddle 0 released between ticks.
        cyc(1, 2'b11, 2'b01, 2'b00);
        chk("ind_idx0", get_idx(0), 3);
        chk("ind_idx1", get_idx(1), 3);
        cyc(0, 2'b10, 2'b01, 2'b00);
        cyc(1, 2'b11, 2'b01, 2'b00);
        chk("ind_rel_idx0", get_idx(0), 4);
        chk("ind_rel_idx1", get_idx(1), 3);

        r_en = 2'b11; r_up = 2'b01;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NP; k++) begin
                if ($urandom_range(0, 9) == 0) r_en[k] = ~r_en[k];
                if ($urandom_range(0, 7) == 0) r_up[k] = ~r_up[k];
                r_c[k] = ($urandom_range(0, 39) == 0);
            end
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cyc(($urandom_range(0, 2) == 0), r_en, r_up, r_c);
        end
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl_multi.md
Name: paddle_ctrl_multi

Overview:
- Parametrised paddle position controller for the LED-matrix air-hockey display. Successor to the fixed 8-row, 3-LED, two-player paddle logic.
- Drives NUM_PADS independent paddles on a ROWS-high column. Each paddle is PAD_LEN contiguous lit rows.
- Moves are gated by a frame tick and use hold-to-auto-repeat (immediate step, delay, then repeat rate). Per-paddle recenter is provided.
- Feeds the ball/collision logic (position masks and indices) and the display driver.

Parameters:
- ROWS, 8, display rows per column (≥ PAD_LEN+1).
- PAD_LEN, 3, paddle length in rows (≥1).
- NUM_PADS, 2, number of independent paddles.
- REPEAT_DLY, 4, ticks held after first step before auto-repeat begins (≥1).
- REPEAT_RATE, 2, ticks between auto-repeat steps (≥1).
- IDXW, $clog2(ROWS), width of a position index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  single-cycle move-timing strobe (frame rate)
- en  in  NUM_PADS  per-paddle move enable (button held)
- up  in  NUM_PADS  per-paddle direction: 1 = toward MSB (up), 0 = toward LSB (down)
- center  in  NUM_PADS  per-paddle recenter request, level, synchronous
- pos_mask  out  NUM_PADS*ROWS  lit-row mask, paddle k at [k*ROWS +: ROWS], active-high (display inverts)
- pos_idx  out  NUM_PADS*IDXW  row index of paddle's lowest lit bit
- at_top  out  NUM_PADS  paddle at upper limit
- at_bot  out  NUM_PADS  paddle at lower limit

Behaviour:
- Encoding:
  - MAX_IDX = ROWS-PAD_LEN.
  - HOME_IDX = (ROWS-PAD_LEN+1)/2, integer division (=3 for defaults).
  - pos_mask = ((1<<PAD_LEN)-1) << pos_idx.
  - at_top = (pos_idx==MAX_IDX); at_bot = (pos_idx==0).
- All outputs are registered or decoded from registered idx only. No input-to-output combinational path.
- Reset (reset==0 at posedge), all paddles: idx=HOME_IDX, FSM=IDLE, counter=0. Default mask is 8'b00111000, at_top=0, at_bot=0. Reset mid-hold aborts the repeat sequence.
- Per-paddle FSM (states IDLE, HOLD, REPEAT), plus a tick counter cnt and last-direction register dir:
  - center[k]=1: highest priority below reset. idx←HOME_IDX, FSM←IDLE, cnt←0, regardless of tick/en.
  - en[k]=0: FSM←IDLE, cnt←0, idx unchanged. Takes effect on any cycle, not only tick cycles.
  - IDLE, tick & en: step once; dir←up; cnt←0; →HOLD.
  - HOLD, tick & en & up==dir: cnt++. When cnt reaches REPEAT_DLY-1: step, cnt←0, →REPEAT.
  - REPEAT, tick & en & up==dir: cnt++. When cnt reaches REPEAT_RATE-1: step, cnt←0.
  - In HOLD or REPEAT, tick & en & up!=dir: treated as a new press. Step immediately in the new direction, dir←up, cnt←0, →HOLD.
  - No tick: state, cnt and idx hold.
- Step rules:
  - up=1 and idx<MAX_IDX: idx+1.
  - up=0 and idx>0: idx-1.
  - At a limit: saturate, idx unchanged. The FSM still advances, so the repeat cadence continues against the wall.
- Latency: a qualifying tick at edge N gives the new idx/mask/flags visible after edge N. Exactly one step per tick maximum.
- Paddles are fully independent. Simultaneous events on different paddles do not interact.
- cnt width: $clog2(max(REPEAT_DLY,REPEAT_RATE))+1.

Decomposition:
- Shared package (airhockey_pkg):
  - ROWS and PAD_LEN defaults.
  - HOME_IDX and MAX_IDX functions.
  - FSM state enum {IDLE, HOLD, REPEAT}.
  - mask-from-index function, reused by the ball/collision block.
- Sub-module paddle_chan: one paddle (FSM, counter, idx, flags).
- Top: generate loop over NUM_PADS, with port slicing/concatenation.

Test Plan:
- Reset, defaults: after reset release, pos_mask=16'h3838, pos_idx={3,3}, at_top=at_bot=0. Assert reset while paddle 0 is at idx 5 → idx returns to 3 on the next edge.
- Single press: en[0]=1, up[0]=1, one tick → idx0=4, mask0=8'b01110000. No further step on the following 3 ticks. Step on the 5th tick (idx0=5), then every 2nd tick.
- Saturation: hold up for 20 ticks → idx0=5, mask0=8'b11100000, at_top[0]=1, never 6. Hold down 20 ticks → idx0=0, mask0=8'b00000111, at_bot[0]=1.
- Direction reversal mid-repeat: in REPEAT at idx 4, flip up→0 on a tick → idx 3 on that tick, next step 4 ticks later.
- Center priority: center[1]=1 together with en[1]=1, tick, from idx 0 → idx1=3, FSM IDLE. After center drops, the next tick with en held steps immediately.
- Independence: paddle 0 up and paddle 1 down on the same ticks → each moves per its own rules. Release en[0] between ticks → paddle 0 returns to IDLE without moving.
